// File: rtl/cpu_pkg.sv
// Shared widths and FSM state type for the 16x8 RAM.
// The pushbutton debouncer uses the FSM state type as well.
package cpu_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        WRITE        = 2'd2,
        WAIT_RELEASE = 2'd3
    } ram_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a raw pushbutton, emitting one single-cycle
// pulse per accepted press. Suitable for any front-panel button.
module button_debouncer
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic enable,
    output logic pressed_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       sync_r;
    logic             btn_s;
    ram_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pulse_r;
    logic             busy_r;

    assign btn_s         = sync_r[1];
    assign pressed_pulse = pulse_r;
    assign busy          = busy_r;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // Press FSM; the pulse is high exactly during WRITE, dropping enable aborts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable && btn_s) begin
                        state_r <= DEBOUNCE;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                DEBOUNCE: begin
                    if (!enable || !btn_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r >= LAST_CNT) begin
                        state_r <= WRITE;
                        pulse_r <= 1'b1;
                    end else if (cnt_r < CNT_MAX) begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (!enable) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!enable || !btn_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/random_access_memory.sv
// 16x8 RAM with combinational reads, bus writes, and debounced manual
// programming from front-panel switches.
module random_access_memory
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              read_from_bus,
    input  logic              write_to_bus,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    input  logic              manual_mode,
    input  logic [DATA_W-1:0] manual_switches,
    input  logic              manual_write,
    output logic [DATA_W-1:0] contents,
    output logic              manual_busy
);

    logic [DATA_W-1:0] mem_r [MEM_DEPTH];
    logic              manual_pulse_s;
    logic              manual_we_s;
    logic              bus_we_s;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .rst          (rst),
        .raw          (manual_write),
        .enable       (manual_mode),
        .pressed_pulse(manual_pulse_s),
        .busy         (manual_busy)
    );

    // A WRITE cycle coinciding with manual_mode falling must not store
    assign manual_we_s = manual_pulse_s && manual_mode;
    assign bus_we_s    = read_from_bus && !manual_mode;

    // Storage array: cleared on reset, one write source at a time by mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (bus_we_s) begin
            mem_r[address] <= bus_in;
        end else if (manual_we_s) begin
            mem_r[address] <= manual_switches;
        end
    end

    // Zero-latency read paths for the LEDs and the bus
    always_comb begin
        contents = mem_r[address];
        if (write_to_bus) begin
            bus_out = mem_r[address];
        end else begin
            bus_out = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_random_access_memory.sv
// Randomized and directed bench for random_access_memory against a
// press-streak behavioural model of the RAM and its manual-write button.
module tb_random_access_memory;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] address;
    logic       read_from_bus;
    logic       write_to_bus;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       manual_mode;
    logic [7:0] manual_switches;
    logic       manual_write;
    logic [7:0] contents;
    logic       manual_busy;

    logic [7:0] m_mem [16];
    int         streak;
    bit         locked;
    bit         m_busy;
    logic       raw_d1;
    logic       raw_d2;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    random_access_memory #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .read_from_bus  (read_from_bus),
        .write_to_bus   (write_to_bus),
        .bus_in         (bus_in),
        .bus_out        (bus_out),
        .manual_mode    (manual_mode),
        .manual_switches(manual_switches),
        .manual_write   (manual_write),
        .contents       (contents),
        .manual_busy    (manual_busy)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        streak = 0;
        locked = 1'b0;
        m_busy = 1'b0;
        raw_d1 = 1'b0;
        raw_d2 = 1'b0;
    endtask

    // A press writes once the button (seen two edges late) and the mode have
    // been high for D+1 consecutive edges; then nothing until one low sample.
    task automatic model_step();
        bit ok;
        ok = manual_mode && raw_d2;
        if (!manual_mode && read_from_bus) m_mem[address] = bus_in;
        if (locked) begin
            if (!ok) begin
                locked = 1'b0;
                streak = 0;
            end
        end else if (streak == D + 1) begin
            streak = 0;
            if (manual_mode) begin
                m_mem[address] = manual_switches;
                locked = 1'b1;
            end
        end else if (ok) begin
            streak++;
        end else begin
            streak = 0;
        end
        m_busy = locked || (streak != 0);
        raw_d2 = raw_d1;
        raw_d1 = manual_write;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        chk("contents", contents, m_mem[address]);
        chk("bus_out", bus_out, write_to_bus ? m_mem[address] : 8'h00);
        chk("manual_busy", {7'd0, manual_busy}, {7'd0, m_busy});
        @(negedge clk);
    endtask

    initial begin
        int hold;
        rst = 1'b1;
        address = 4'h0;
        read_from_bus = 1'b0;
        write_to_bus = 1'b1;
        bus_in = 8'h00;
        manual_mode = 1'b0;
        manual_switches = 8'h00;
        manual_write = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_contents", contents, 8'h00);
        chk("reset_bus_out", bus_out, 8'h00);
        chk("reset_busy", {7'd0, manual_busy}, 8'h00);
        cycle();
        rst = 1'b0;
        write_to_bus = 1'b0;
        cycle();

        // Bus write then read, and simultaneous read/write
        address = 4'h3; bus_in = 8'hA5; read_from_bus = 1'b1;
        cycle();
        read_from_bus = 1'b0; write_to_bus = 1'b1; #1;
        chk("bus_rd_a5", bus_out, 8'hA5);
        chk("contents_a5", contents, 8'hA5);
        write_to_bus = 1'b0; #1;
        chk("bus_idle_zero", bus_out, 8'h00);
        cycle();
        bus_in = 8'h5A; read_from_bus = 1'b1; write_to_bus = 1'b1; #1;
        chk("rw_same_old", bus_out, 8'hA5);
        cycle();
        read_from_bus = 1'b0; #1;
        chk("rw_same_new", bus_out, 8'h5A);
        write_to_bus = 1'b0;
        cycle();

        // Manual program with a 20-cycle hold
        manual_mode = 1'b1; address = 4'hF; manual_switches = 8'h3C; manual_write = 1'b1;
        repeat (2) cycle();
        chk("busy_before_sync", {7'd0, manual_busy}, 8'h00);
        cycle();
        chk("busy_debounce", {7'd0, manual_busy}, 8'h01);
        repeat (4) cycle();
        chk("pre_write", contents, 8'h00);
        cycle();
        chk("manual_write", contents, 8'h3C);
        manual_switches = 8'h77;
        repeat (12) cycle();
        chk("single_write", contents, 8'h3C);
        manual_write = 1'b0;
        cycle();
        chk("busy_rel1", {7'd0, manual_busy}, 8'h01);
        cycle();
        chk("busy_rel2", {7'd0, manual_busy}, 8'h01);
        cycle();
        chk("busy_rel3", {7'd0, manual_busy}, 8'h00);

        // Bounce rejection
        manual_switches = 8'h99;
        repeat (6) begin
            manual_write = 1'b1; cycle(); cycle();
            manual_write = 1'b0; cycle();
        end
        repeat (4) cycle();
        chk("bounce_reject", contents, 8'h3C);

        // Mode masking of bus writes and mode drop during debounce
        address = 4'h0; bus_in = 8'hFF; read_from_bus = 1'b1;
        cycle();
        read_from_bus = 1'b0; #1;
        chk("mode_mask", contents, 8'h00);
        manual_switches = 8'h55; manual_write = 1'b1;
        repeat (4) cycle();
        chk("busy_before_drop", {7'd0, manual_busy}, 8'h01);
        manual_mode = 1'b0;
        cycle();
        chk("mode_drop_idle", {7'd0, manual_busy}, 8'h00);
        manual_write = 1'b0;
        repeat (4) cycle();
        manual_mode = 1'b1;
        repeat (4) cycle();
        chk("no_write_after_drop", contents, 8'h00);

        // Mode drop in the WRITE cycle itself
        manual_switches = 8'h66; manual_write = 1'b1;
        repeat (7) cycle();
        manual_mode = 1'b0;
        cycle();
        chk("drop_in_write", contents, 8'h00);
        manual_write = 1'b0;
        repeat (4) cycle();

        // Fill, then reset mid-debounce
        for (int i = 0; i < 16; i++) begin
            address = 4'(i); bus_in = 8'($urandom_range(1, 255)); read_from_bus = 1'b1;
            cycle();
        end
        read_from_bus = 1'b0;
        manual_mode = 1'b1; address = 4'h2; manual_switches = 8'hAA; manual_write = 1'b1;
        repeat (4) cycle();
        #2 rst = 1'b1; #1;
        chk("rst_async_contents", contents, 8'h00);
        chk("rst_async_busy", {7'd0, manual_busy}, 8'h00);
        manual_write = 1'b0;
        @(negedge clk);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            address = 4'(i); #1;
            chk("rst_cleared", contents, 8'h00);
            cycle();
        end

        // Reset mid-press with the button still held afterwards
        address = 4'h7; manual_switches = 8'hC3; manual_write = 1'b1;
        repeat (4) cycle();
        #2 rst = 1'b1;
        @(negedge clk);
        cycle();
        rst = 1'b0;
        repeat (7) cycle();
        chk("post_rst_pre", contents, 8'h00);
        cycle();
        chk("post_rst_write", contents, 8'hC3);
        repeat (4) cycle();
        manual_write = 1'b0;
        repeat (4) cycle();

        // Address sweep via the bus
        manual_mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            address = 4'(i); bus_in = 8'h10 + 8'(i); read_from_bus = 1'b1;
            cycle();
        end
        read_from_bus = 1'b0; write_to_bus = 1'b1;
        for (int i = 0; i < 16; i++) begin
            address = 4'(i); #1;
            chk("sweep", bus_out, 8'h10 + 8'(i));
            cycle();
        end

        // Randomized traffic
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                manual_write = ~manual_write;
                hold = $urandom_range(1, 14);
            end
            hold--;
            if ($urandom_range(0, 49) == 0) manual_mode = ~manual_mode;
            address = 4'($urandom);
            read_from_bus = ($urandom_range(0, 2) == 0);
            write_to_bus = 1'($urandom);
            bus_in = 8'($urandom);
            manual_switches = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/random_access_memory.md
RANDOM_ACCESS_MEMORY -- requirements
Module: random_access_memory

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable-high clk samples required to accept a manual write press.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port address, input, 4, the word address from the memory address register.
REQ-005 The block SHALL have port read_from_bus, input, 1, the bus write enable: store bus_in at address.
REQ-006 The block SHALL have port write_to_bus, input, 1, the bus drive enable: present the addressed word on bus_out.
REQ-007 The block SHALL have port bus_in, input, 8, the data bus value.
REQ-008 The block SHALL have port bus_out, output, 8, the addressed word when write_to_bus is high, else 8'h00.
REQ-009 The block SHALL have port manual_mode, input, 1, programming mode select, shared with the memory address register.
REQ-010 The block SHALL have port manual_switches, input, 8, the data value to program in manual mode.
REQ-011 The block SHALL have port manual_write, input, 1, the raw asynchronous program pushbutton, active-high.
REQ-012 The block SHALL have port contents, output, 8, the addressed word for the LEDs, always valid.
REQ-013 The block SHALL have port manual_busy, output, 1, high while the manual-write FSM is not in IDLE.

Function
REQ-014 The block SHALL store 16 words of 8 bits each.
REQ-015 Reads SHALL be combinational: contents = mem[address]; bus_out = write_to_bus ? mem[address] : 8'h00; zero latency.
REQ-016 When manual_mode=0 and read_from_bus=1, the block SHALL write mem[address] <= bus_in on the clk edge; the new value appears on contents in the following cycle.
REQ-017 When manual_mode=1, the block SHALL ignore read_from_bus.
REQ-018 When write_to_bus and read_from_bus are both high in the same cycle, bus_out SHALL show the old word and the write SHALL commit at the edge.
REQ-019 The block SHALL pass manual_write through a 2-flop synchronizer before any use.
REQ-020 The manual-write FSM SHALL have states IDLE, DEBOUNCE, WRITE, WAIT_RELEASE.
REQ-021 FSM transition IDLE->DEBOUNCE: taken when manual_mode=1 and the synchronized button is high; the debounce counter is cleared.
REQ-022 FSM in DEBOUNCE: button low -> IDLE; counter reaching DEBOUNCE_CYCLES-1 with the button high -> WRITE.
REQ-023 FSM in WRITE: exactly one cycle, writing mem[address] <= manual_switches, then -> WAIT_RELEASE.
REQ-024 FSM in WAIT_RELEASE: the block SHALL stay until the synchronized button is low for one cycle, then -> IDLE; a held button SHALL give exactly one write.
REQ-025 manual_mode falling in any state SHALL force the FSM to IDLE next cycle; if the FSM is in WRITE in the same cycle, no write SHALL occur.
REQ-026 The debounce counter SHALL saturate and SHALL not wrap; its width is $clog2(DEBOUNCE_CYCLES)+1.
REQ-027 Address changes during DEBOUNCE SHALL be allowed; the write SHALL use the address present in the WRITE cycle.

Reset
REQ-028 rst SHALL asynchronously clear all 16 words to 8'h00, the FSM to IDLE, the counter and synchronizer flops to 0.
REQ-029 During reset, contents=8'h00, bus_out=8'h00 and manual_busy=0.
REQ-030 Reset asserted mid-press SHALL abort the write; after release with the button still held, the FSM SHALL re-enter DEBOUNCE and perform one write.

Structure
REQ-031 Package cpu_pkg SHALL hold ADDR_W=4, DATA_W=8, MEM_DEPTH=16 and the typedef ram_state_t for the FSM states.
REQ-032 The synchronizer and debounce logic SHALL be a sub-module button_debouncer (ports clk, rst, raw, enable, pressed_pulse, busy), reusable for other pushbuttons.

Verification
REQ-033 Bus write/read: address=4'h3, bus_in=8'hA5, read_from_bus=1 for 1 cycle, then write_to_bus=1 -> bus_out=8'hA5 and contents=8'hA5; with write_to_bus=0 -> bus_out=8'h00.
REQ-034 Manual program: manual_mode=1, address=4'hF, manual_switches=8'h3C, button held 20 cycles -> mem[F]=8'h3C, exactly one WRITE cycle, manual_busy high until release+1.
REQ-035 Bounce rejection: button pulses high 2 cycles, low 1, repeated (DEBOUNCE_CYCLES=4) -> no write; mem[F] is unchanged.
REQ-036 Mode masking: manual_mode=1, read_from_bus=1, bus_in=8'hFF at address 4'h0 -> mem[0] stays 8'h00; manual_mode drops during DEBOUNCE -> FSM returns to IDLE and no write occurs.
REQ-037 Reset: fill all 16 words, assert rst between clock edges mid-DEBOUNCE -> contents=8'h00 immediately; all words read 8'h00 after release.
REQ-038 Sweep: write 8'h10+i to address i for i=0..15 via bus, then read back all 16 -> all match and address 4'hF does not alias 4'h0.
